// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types for the cache-to-RAM arbiter: word type, RAM handshake state, arbiter FSM state.
package cache_mem_arbiter_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic {
        ARB   = 1'b0,
        SERVE = 1'b1
    } arb_state_t;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Index of the set bit in a one-hot vector (0 when empty).
    function automatic int onehot_idx(input logic [31:0] v);
        int r;
        r = 0;
        for (int k = 0; k < 32; k++) begin
            if (v[k]) r = k;
        end
        return r;
    endfunction

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Cache-side request/response lines for CPUS i/d cache pairs plus the single RAM port.
interface cache_mem_arbiter_if
    import cache_mem_arbiter_pkg::*;
#(
    parameter int CPUS = 2
) ();
    logic  [CPUS-1:0] iREN;
    word_t [CPUS-1:0] iaddr;
    logic  [CPUS-1:0] dREN;
    logic  [CPUS-1:0] dWEN;
    word_t [CPUS-1:0] daddr;
    word_t [CPUS-1:0] dstore;
    logic  [CPUS-1:0] iwait;
    logic  [CPUS-1:0] dwait;
    word_t [CPUS-1:0] iload;
    word_t [CPUS-1:0] dload;

    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;
    logic      ram_err;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, ram_err
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, ram_err
    );
endinterface

// File: rtl/cache_mem_arbiter_rr_picker.sv
// Round-robin picker: first requester at or after ptr, one-hot grant. Purely combinational.
module cache_mem_arbiter_rr_picker
    import cache_mem_arbiter_pkg::*;
#(
    parameter int N  = 2,
    parameter int PW = ptr_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic          valid
);
    int cand;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        cand  = 0;
        for (int k = 0; k < N; k++) begin
            cand = (int'(ptr) + k) % N;
            if (!valid && req[cand]) begin
                grant[cand] = 1'b1;
                valid       = 1'b1;
            end
        end
    end
endmodule

// File: rtl/cache_mem_arbiter.sv
// Grants one i/d cache request at a time to the single-port RAM; wait drops in the RAM's ACCESS/ERROR cycle.
// Requesters hold their enable until wait is low; dropping it early aborts the access without a wait pulse.
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int    CPUS     = 2,
    parameter word_t ERR_WORD = 32'hBAD1BAD1
) (
    input logic                CLK,
    input logic                nRST,
    cache_mem_arbiter_if.slave bus
);
    localparam int PW = ptr_width(CPUS);

    arb_state_t       state;
    logic [PW-1:0]    rr_ptr, cpu, next_ptr, d_idx, i_idx;
    logic             is_data, is_write, ram_err_q;
    word_t [CPUS-1:0] iload_q, dload_q;
    logic [CPUS-1:0]  d_req, d_grant, i_grant;
    logic             d_vld, i_vld;
    logic             live, active, done, fail;
    word_t            load_val;

    assign d_req = bus.dREN | bus.dWEN;

    cache_mem_arbiter_rr_picker #(.N(CPUS)) u_pick_d (
        .req   (d_req),
        .ptr   (rr_ptr),
        .grant (d_grant),
        .valid (d_vld)
    );

    cache_mem_arbiter_rr_picker #(.N(CPUS)) u_pick_i (
        .req   (bus.iREN),
        .ptr   (rr_ptr),
        .grant (i_grant),
        .valid (i_vld)
    );

    assign d_idx    = PW'(onehot_idx(32'(d_grant)));
    assign i_idx    = PW'(onehot_idx(32'(i_grant)));
    assign next_ptr = (cpu == PW'(CPUS - 1)) ? '0 : cpu + 1'b1;
    assign bus.ram_err = ram_err_q;

    // RAM port follows the granted requester's live lines so a dropped enable idles RAM immediately.
    always_comb begin
        live     = is_data ? d_req[cpu] : bus.iREN[cpu];
        active   = (state == SERVE) && nRST && live;
        done     = active && (bus.ramstate == ACCESS || bus.ramstate == ERROR);
        fail     = active && (bus.ramstate == ERROR);
        load_val = fail ? ERR_WORD : bus.ramload;

        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        if (state == SERVE && nRST) begin
            bus.ramaddr  = is_data ? bus.daddr[cpu] : bus.iaddr[cpu];
            bus.ramstore = is_data ? bus.dstore[cpu] : '0;
        end
        if (active) begin
            if (is_data) begin
                bus.ramWEN = bus.dWEN[cpu];
                bus.ramREN = bus.dREN[cpu] & ~bus.dWEN[cpu];
            end else begin
                bus.ramREN = 1'b1;
            end
        end

        bus.iwait = '1;
        bus.dwait = '1;
        bus.iload = iload_q;
        bus.dload = dload_q;
        if (done) begin
            if (is_data) begin
                bus.dwait[cpu] = 1'b0;
                if (!is_write) bus.dload[cpu] = load_val;
            end else begin
                bus.iwait[cpu] = 1'b0;
                bus.iload[cpu] = load_val;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state     <= ARB;
            rr_ptr    <= '0;
            cpu       <= '0;
            is_data   <= 1'b0;
            is_write  <= 1'b0;
            ram_err_q <= 1'b0;
            iload_q   <= '0;
            dload_q   <= '0;
        end else begin
            case (state)
                ARB: begin
                    if (d_vld) begin
                        cpu      <= d_idx;
                        is_data  <= 1'b1;
                        is_write <= |(bus.dWEN & d_grant);
                        state    <= SERVE;
                    end else if (i_vld) begin
                        cpu      <= i_idx;
                        is_data  <= 1'b0;
                        is_write <= 1'b0;
                        state    <= SERVE;
                    end
                end
                SERVE: begin
                    if (!live) begin
                        state <= ARB;
                    end else if (done) begin
                        state  <= ARB;
                        rr_ptr <= next_ptr;
                        if (fail) ram_err_q <= 1'b1;
                        if (!is_data) iload_q[cpu] <= load_val;
                        else if (!is_write) dload_q[cpu] <= load_val;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench: per-CPU request queues drive the arbiter, a RAM model answers, a scoreboard checks completions.
module tb_cache_mem_arbiter;
    import cache_mem_arbiter_pkg::*;

    localparam int    CPUS = 2;
    localparam word_t ERRW = 32'hBAD1BAD1;

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    cache_mem_arbiter_if #(.CPUS(CPUS)) bus ();
    cache_mem_arbiter #(.CPUS(CPUS), .ERR_WORD(ERRW)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));

    typedef struct {
        bit    wr;
        bit    rd_too;
        word_t addr;
        word_t data;
    } req_t;

    typedef struct {
        bit    is_data;
        bit    is_write;
        int    cpu;
        word_t addr;
        word_t load;
        bit    err_before;
    } exp_t;

    int    total = 0;
    int    bad   = 0;
    req_t  iq [CPUS][$];
    req_t  dq [CPUS][$];
    exp_t  expq [$];
    word_t ref_mem [word_t];
    word_t ram_mem [word_t];
    int    m_ptr;
    bit    m_err;
    word_t m_iload [CPUS];
    word_t m_dload [CPUS];
    bit    done_i [CPUS];
    bit    done_d [CPUS];
    bit    mon_en = 1'b0;
    int    lat_fixed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic word_t mem_default(input word_t a);
        return {~a[15:0], a[15:0]} ^ 32'h1234_0000;
    endfunction

    function automatic bit is_err_addr(input word_t a);
        return a[31:28] == 4'hE;
    endfunction

    function automatic req_t mk_req(input bit wr, input bit rd_too, input word_t addr, input word_t data);
        req_t r;
        r.wr = wr; r.rd_too = rd_too; r.addr = addr; r.data = data;
        return r;
    endfunction

    function automatic req_t rand_req(input bit data);
        word_t a;
        a = word_t'($urandom_range(0, 15)) << 2;
        if ($urandom_range(0, 7) == 0) a = a | 32'hE000_0000;
        return mk_req(data && ($urandom_range(0, 1) == 1), $urandom_range(0, 3) == 0, a, $urandom);
    endfunction

    // RAM model: per access, lat_fixed (or random 0..3) BUSY cycles then ACCESS, ERROR for 0xE... addresses.
    int acc_cnt, acc_lat;
    bit prev_act = 1'b0;
    initial begin
        bus.ramstate = FREE;
        bus.ramload  = '0;
        forever begin
            @(posedge CLK);
            #2;
            if (!(bus.ramREN || bus.ramWEN)) begin
                bus.ramstate = FREE;
                prev_act     = 1'b0;
            end else begin
                if (!prev_act) begin
                    acc_cnt = 0;
                    acc_lat = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
                end else begin
                    acc_cnt++;
                end
                prev_act     = 1'b1;
                bus.ramload  = $urandom;
                if (acc_cnt < acc_lat) begin
                    bus.ramstate = BUSY;
                end else if (is_err_addr(bus.ramaddr)) begin
                    bus.ramstate = ERROR;
                end else begin
                    bus.ramstate = ACCESS;
                    if (bus.ramWEN) ram_mem[bus.ramaddr] = bus.ramstore;
                    else bus.ramload = ram_mem.exists(bus.ramaddr) ? ram_mem[bus.ramaddr] : mem_default(bus.ramaddr);
                end
            end
        end
    end

    // Reference: data class beats instruction class, each round-robin from one shared pointer.
    task automatic predict();
        req_t qi [CPUS][$];
        req_t qd [CPUS][$];
        req_t r;
        exp_t e;
        int   pick, c;
        bit   pd, err;
        for (int k = 0; k < CPUS; k++) begin
            qi[k] = iq[k];
            qd[k] = dq[k];
        end
        for (int guard = 0; guard < 1000; guard++) begin
            pick = -1;
            pd   = 1'b0;
            for (int k = 0; k < CPUS; k++) begin
                c = (m_ptr + k) % CPUS;
                if (pick < 0 && qd[c].size() > 0) begin pick = c; pd = 1'b1; end
            end
            for (int k = 0; k < CPUS; k++) begin
                c = (m_ptr + k) % CPUS;
                if (pick < 0 && qi[c].size() > 0) pick = c;
            end
            if (pick < 0) break;
            if (pd) r = qd[pick].pop_front();
            else    r = qi[pick].pop_front();
            err          = is_err_addr(r.addr);
            e.is_data    = pd;
            e.is_write   = pd && r.wr;
            e.cpu        = pick;
            e.addr       = r.addr;
            e.err_before = m_err;
            if (e.is_write) begin
                e.load = m_dload[pick];
                if (!err) ref_mem[r.addr] = r.data;
            end else begin
                e.load = err ? ERRW : (ref_mem.exists(r.addr) ? ref_mem[r.addr] : mem_default(r.addr));
                if (pd) m_dload[pick] = e.load;
                else    m_iload[pick] = e.load;
            end
            if (err) m_err = 1'b1;
            m_ptr = (pick + 1) % CPUS;
            expq.push_back(e);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0;
        m_err = 1'b0;
        for (int k = 0; k < CPUS; k++) begin
            m_iload[k] = '0;
            m_dload[k] = '0;
            done_i[k]  = 1'b0;
            done_d[k]  = 1'b0;
        end
    endtask

    task automatic apply_heads();
        req_t r;
        for (int c = 0; c < CPUS; c++) begin
            if (iq[c].size() > 0) begin
                bus.iREN[c]  = 1'b1;
                bus.iaddr[c] = iq[c][0].addr;
            end else begin
                bus.iREN[c] = 1'b0;
            end
            if (dq[c].size() > 0) begin
                r = dq[c][0];
                bus.dWEN[c]   = r.wr;
                bus.dREN[c]   = !r.wr || r.rd_too;
                bus.daddr[c]  = r.addr;
                bus.dstore[c] = r.data;
            end else begin
                bus.dREN[c] = 1'b0;
                bus.dWEN[c] = 1'b0;
            end
        end
    endtask

    function automatic bit all_empty();
        for (int c = 0; c < CPUS; c++) begin
            if (iq[c].size() > 0 || dq[c].size() > 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Starts and ends at posedge+1.
    task automatic run_round(input string tag);
        predict();
        apply_heads();
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(posedge CLK);
            #1;
            for (int c = 0; c < CPUS; c++) begin
                if (done_i[c]) begin done_i[c] = 1'b0; if (iq[c].size() > 0) void'(iq[c].pop_front()); end
                if (done_d[c]) begin done_d[c] = 1'b0; if (dq[c].size() > 0) void'(dq[c].pop_front()); end
            end
            apply_heads();
            if (all_empty()) break;
        end
        if (!all_empty()) begin
            check({tag, "_timeout_pending"}, 1, 0);
            for (int c = 0; c < CPUS; c++) begin iq[c].delete(); dq[c].delete(); end
            apply_heads();
        end
        repeat (3) @(posedge CLK);
        #1;
        check({tag, "_scoreboard_left"}, expq.size(), 0);
        expq.delete();
    endtask

    task automatic wait_ram_active(input string tag);
        for (int k = 0; k < 20; k++) begin
            if (bus.ramREN || bus.ramWEN) return;
            @(posedge CLK);
            #1;
        end
        check({tag, "_ram_active_timeout"}, 0, 1);
    endtask

    task automatic monitor_step();
        int   nlow, c_hit;
        bit   hit_d;
        exp_t e;
        nlow  = 0;
        c_hit = 0;
        hit_d = 1'b0;
        for (int c = 0; c < CPUS; c++) begin
            if (bus.iwait[c] === 1'b0) begin nlow++; c_hit = c; hit_d = 1'b0; end
            if (bus.dwait[c] === 1'b0) begin nlow++; c_hit = c; hit_d = 1'b1; end
        end
        if (nlow == 0) return;
        check("wait_lines_low", nlow, 1);
        if (expq.size() == 0) begin
            check("unexpected_completion_port", c_hit * 2 + int'(hit_d), 32'hFFFF_FFFF);
        end else begin
            e = expq.pop_front();
            check("grant_port", c_hit * 2 + int'(hit_d), e.cpu * 2 + int'(e.is_data));
            check("ramaddr", bus.ramaddr, e.addr);
            check("ramWEN", bus.ramWEN, e.is_write);
            check("ramREN", bus.ramREN, !e.is_write);
            check("load", e.is_data ? bus.dload[e.cpu] : bus.iload[e.cpu], e.load);
            check("ram_err_before", bus.ram_err, e.err_before);
        end
        if (hit_d) done_d[c_hit] = 1'b1;
        else       done_i[c_hit] = 1'b1;
    endtask

    initial begin
        forever begin
            @(negedge CLK);
            if (mon_en) monitor_step();
        end
    end

    initial begin
        nRST       = 1'b0;
        bus.iREN   = '1;
        bus.dREN   = '1;
        bus.dWEN   = '0;
        bus.iaddr  = '0;
        bus.daddr  = '0;
        bus.dstore = '0;
        model_reset();

        repeat (3) @(posedge CLK);
        #1;
        check("rst_iwait", bus.iwait, {CPUS{1'b1}});
        check("rst_dwait", bus.dwait, {CPUS{1'b1}});
        check("rst_ram_en", {bus.ramREN, bus.ramWEN}, 0);
        check("rst_ramaddr", bus.ramaddr, 0);
        check("rst_ram_err", bus.ram_err, 0);
        check("rst_iload0", bus.iload[0], 0);
        check("rst_dload1", bus.dload[1], 0);
        bus.iREN = '0;
        bus.dREN = '0;
        nRST     = 1'b1;
        mon_en   = 1'b1;

        // Single instruction fetch behind two BUSY cycles.
        lat_fixed = 2;
        ram_mem[32'h40] = 32'h8C22_0004;
        ref_mem[32'h40] = 32'h8C22_0004;
        iq[0].push_back(mk_req(0, 0, 32'h40, 0));
        run_round("ifetch");
        check("ifetch_iload_held", bus.iload[0], 32'h8C22_0004);

        // Simultaneous ifetch and data write: write goes first, then read it back.
        lat_fixed = 0;
        iq[0].push_back(mk_req(0, 0, 32'h80, 0));
        dq[1].push_back(mk_req(1, 0, 32'h100, 32'hDEAD_BEEF));
        run_round("write_first");
        dq[0].push_back(mk_req(0, 0, 32'h100, 0));
        run_round("readback");

        // Two continuous data readers with a zero-wait RAM must alternate.
        for (int k = 0; k < 10; k++) begin
            dq[0].push_back(mk_req(0, 0, word_t'(k) << 2, 0));
            dq[1].push_back(mk_req(0, 0, word_t'(k + 16) << 2, 0));
        end
        run_round("alternate");

        // RAM error on a CPU1 data read.
        dq[1].push_back(mk_req(0, 0, 32'hE000_0010, 0));
        run_round("ram_error");
        check("ram_err_set", bus.ram_err, 1);

        lat_fixed = -1;
        for (int r = 0; r < 25; r++) begin
            for (int c = 0; c < CPUS; c++) begin
                repeat ($urandom_range(0, 3)) iq[c].push_back(rand_req(0));
                repeat ($urandom_range(0, 3)) dq[c].push_back(rand_req(1));
            end
            run_round("random");
        end
        check("ram_err_sticky", bus.ram_err, 1);

        // Abort: CPU0 drops its read while RAM is still BUSY.
        lat_fixed = 5;
        dq[0].push_back(mk_req(0, 0, 32'h44, 0));
        apply_heads();
        wait_ram_active("abort");
        dq[0].delete();
        apply_heads();
        #1;
        check("abort_ramREN_same_cycle", bus.ramREN, 0);
        @(negedge CLK);
        check("abort_no_dwait", bus.dwait, {CPUS{1'b1}});
        @(posedge CLK);
        #1;
        check("abort_ram_idle", {bus.ramREN, bus.ramWEN}, 0);
        lat_fixed = 0;
        dq[0].push_back(mk_req(0, 0, 32'h8, 0));
        dq[1].push_back(mk_req(0, 0, 32'hC, 0));
        run_round("after_abort");

        // Reset while serving drops the access and clears everything.
        lat_fixed = 5;
        dq[1].push_back(mk_req(0, 0, 32'h48, 0));
        apply_heads();
        wait_ram_active("rst_serve");
        nRST = 1'b0;
        dq[1].delete();
        apply_heads();
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        model_reset();
        check("rst_serve_ram_en", {bus.ramREN, bus.ramWEN}, 0);
        check("rst_serve_ramaddr", bus.ramaddr, 0);
        check("rst_serve_ram_err", bus.ram_err, 0);
        check("rst_serve_dwait", bus.dwait, {CPUS{1'b1}});
        check("rst_serve_dload1", bus.dload[1], 0);
        check("rst_serve_iload0", bus.iload[0], 0);
        lat_fixed = 1;
        dq[0].push_back(mk_req(0, 0, 32'h100, 0));
        dq[1].push_back(mk_req(0, 0, 32'h40, 0));
        run_round("after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
